// File: rtl/boreal_phase_tracker_mc.sv
// Multi-channel phase tracker: per-channel rising zero-crossing detection with hysteresis,
// EMA period estimation, lock qualification and two programmable-phase trigger pulses.
module boreal_phase_tracker_mc #(
    parameter int NCH        = 4,
    parameter int CHW        = 2,
    parameter int DATA_W     = 16,
    parameter int CNT_W      = 16,
    parameter int PH_W       = 8,
    parameter int MIN_PERIOD = 20,
    parameter int MAX_PERIOD = 500,
    parameter int HYST       = 0,
    parameter int TOL        = 20,
    parameter int LOCK_COUNT = 3,
    parameter int EMA_SHIFT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [CHW-1:0]    in_chan,
    input  logic [DATA_W-1:0] in_sample,
    input  logic [PH_W-1:0]   cfg_phase_a,
    input  logic [PH_W-1:0]   cfg_phase_b,
    output logic              out_valid,
    output logic [CHW-1:0]    out_chan,
    output logic              out_crossing,
    output logic              out_trig_a,
    output logic              out_trig_b,
    output logic              out_locked,
    output logic [CNT_W-1:0]  out_period,
    output logic [NCH-1:0]    lock_mask
);
    localparam int SW = $clog2(LOCK_COUNT + 1);
    localparam int PW = CNT_W + PH_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic signed [DATA_W-1:0] HYST_P = DATA_W'(HYST);
    localparam logic signed [DATA_W-1:0] HYST_N = -HYST_P;

    logic             above_reg       [NCH];
    logic [CNT_W-1:0] period_cnt_reg  [NCH];
    logic [CNT_W-1:0] est_reg         [NCH];
    logic [CNT_W-1:0] last_period_reg [NCH];
    logic [SW-1:0]    stable_cnt_reg  [NCH];
    logic             locked_reg      [NCH];
    logic [CNT_W-1:0] trig_a_at_reg   [NCH];
    logic [CNT_W-1:0] trig_b_at_reg   [NCH];

    logic [NCH-1:0]   chan_sel;
    logic             chan_ok;
    logic             cur_above, cur_locked;
    logic [CNT_W-1:0] cur_cnt, cur_est, cur_last, cur_ta, cur_tb;
    logic [SW-1:0]    cur_stable;

    // Channel mux built from explicit compares so out-of-range indices simply never match.
    always_comb begin
        chan_sel   = '0;
        cur_above  = 1'b0;
        cur_locked = 1'b0;
        cur_cnt    = '0;
        cur_est    = '0;
        cur_last   = '0;
        cur_ta     = '0;
        cur_tb     = '0;
        cur_stable = '0;
        for (int i = 0; i < NCH; i++) begin
            if (in_chan == CHW'(i)) begin
                chan_sel[i] = 1'b1;
                cur_above   = above_reg[i];
                cur_locked  = locked_reg[i];
                cur_cnt     = period_cnt_reg[i];
                cur_est     = est_reg[i];
                cur_last    = last_period_reg[i];
                cur_ta      = trig_a_at_reg[i];
                cur_tb      = trig_b_at_reg[i];
                cur_stable  = stable_cnt_reg[i];
            end
        end
    end

    assign chan_ok = in_valid && (|chan_sel);

    logic                    crossing, above_next, meas_valid, stable;
    logic [CNT_W-1:0]        cnt_inc, cnt_next, est_next, last_next, ta_next, tb_next;
    logic signed [CNT_W:0]   ema_diff, ema_sum, last_diff, last_abs;
    logic [SW-1:0]           stable_next, stable_sat;
    logic                    locked_next, fire_a, fire_b;
    logic [PW-1:0]           prod_a, prod_b;

    always_comb begin
        cnt_inc    = (cur_cnt == CNT_MAX) ? CNT_MAX : cur_cnt + 1'b1;
        crossing   = !cur_above && ($signed(in_sample) > HYST_P);
        above_next = cur_above;
        if (crossing)
            above_next = 1'b1;
        else if (cur_above && ($signed(in_sample) < HYST_N))
            above_next = 1'b0;

        // cnt_inc doubles as the measured period when this sample is a crossing
        meas_valid = (cnt_inc >= CNT_W'(MIN_PERIOD)) && (cnt_inc <= CNT_W'(MAX_PERIOD));
        ema_diff   = $signed({1'b0, cnt_inc}) - $signed({1'b0, cur_est});
        ema_sum    = $signed({1'b0, cur_est}) + (ema_diff >>> EMA_SHIFT);
        last_diff  = $signed({1'b0, cnt_inc}) - $signed({1'b0, cur_last});
        last_abs   = (last_diff < 0) ? -last_diff : last_diff;
        stable     = meas_valid && (last_abs <= $signed((CNT_W+1)'(TOL)));
        stable_sat = (cur_stable >= SW'(LOCK_COUNT)) ? SW'(LOCK_COUNT) : cur_stable + 1'b1;

        cnt_next    = cnt_inc;
        est_next    = cur_est;
        last_next   = cur_last;
        stable_next = cur_stable;
        locked_next = cur_locked;
        ta_next     = cur_ta;
        tb_next     = cur_tb;
        prod_a      = '0;
        prod_b      = '0;

        if (crossing) begin
            cnt_next  = '0;
            last_next = cnt_inc;
            if (meas_valid)
                est_next = (cur_est == '0) ? cnt_inc : ema_sum[CNT_W-1:0];
            if (stable) begin
                stable_next = stable_sat;
                locked_next = (stable_sat == SW'(LOCK_COUNT));
            end else begin
                stable_next = '0;
                locked_next = 1'b0;
            end
            prod_a  = PW'(est_next) * PW'(cfg_phase_a);
            prod_b  = PW'(est_next) * PW'(cfg_phase_b);
            ta_next = prod_a[PW-1:PH_W];
            tb_next = prod_b[PW-1:PH_W];
        end else if (cnt_inc > CNT_W'(MAX_PERIOD)) begin
            // Loss of signal: drop lock but keep the period estimate for reacquisition
            stable_next = '0;
            locked_next = 1'b0;
        end

        fire_a = locked_next && (cnt_next == ta_next);
        fire_b = locked_next && (cnt_next == tb_next);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    above_reg[gi]       <= 1'b0;
                    period_cnt_reg[gi]  <= '0;
                    est_reg[gi]         <= '0;
                    last_period_reg[gi] <= '0;
                    stable_cnt_reg[gi]  <= '0;
                    locked_reg[gi]      <= 1'b0;
                    trig_a_at_reg[gi]   <= '0;
                    trig_b_at_reg[gi]   <= '0;
                end else if (in_valid && chan_sel[gi]) begin
                    above_reg[gi]       <= above_next;
                    period_cnt_reg[gi]  <= cnt_next;
                    est_reg[gi]         <= est_next;
                    last_period_reg[gi] <= last_next;
                    stable_cnt_reg[gi]  <= stable_next;
                    locked_reg[gi]      <= locked_next;
                    trig_a_at_reg[gi]   <= ta_next;
                    trig_b_at_reg[gi]   <= tb_next;
                end
            end
            assign lock_mask[gi] = locked_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_chan     <= '0;
            out_crossing <= 1'b0;
            out_trig_a   <= 1'b0;
            out_trig_b   <= 1'b0;
            out_locked   <= 1'b0;
            out_period   <= '0;
        end else begin
            out_valid    <= chan_ok;
            out_crossing <= chan_ok && crossing;
            out_trig_a   <= chan_ok && fire_a;
            out_trig_b   <= chan_ok && fire_b;
            if (chan_ok) begin
                out_chan   <= in_chan;
                out_locked <= locked_next;
                out_period <= est_next;
            end
        end
    end
endmodule
